zvc_line_packer: RTL
====================

Name: zvc_line_packer

Overview:
- Sits directly downstream of the 128-entry zero-value compressor.
- Each compressed line carries a variable number of valid entries, packed toward index 0.
- This block concatenates those entries across successive lines into dense, full 128-entry output lines, using a valid/ready stream.
- A flush request drains the remaining partial line, zero-padded, with a valid count.

Parameters:
- WORD_WIDTH, 8, width of one LIFM word.
- DIST_WIDTH, 7, width of one mapping-table distance field.
- MAX_LIFM_RSIZ, 4, distance fields per mapping-table entry.
- LINE_SIZE, 128, entries per line, on both input and output.

Ports:
- clk  in  1  Clock; all state updates on its rising edge.
- reset  in  1  Synchronous, active-high reset.
- in_valid  in  1  Input line valid.
- in_ready  out  1  Packer accepts the input line this cycle.
- lifm_comp  in  LINE_SIZE*WORD_WIDTH  Compressed LIFM line.
- mt_comp  in  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  Compressed mapping-table line.
- flush_req  in  1  Single-cycle request to drain the buffer.
- out_valid  out  1  Output line valid.
- out_ready  in  1  Downstream accepts the output line.
- lifm_out  out  LINE_SIZE*WORD_WIDTH  Packed LIFM line.
- mt_out  out  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  Packed mapping-table line.
- out_cnt  out  $clog2(LINE_SIZE)+1  Valid entries in the output line (1..LINE_SIZE).
- out_last  out  1  Final line of a flush.
- flush_done  out  1  One-cycle pulse when a flush completes.

Behaviour:
- Entry layout:
  - An entry is {mt field, lifm word}.
  - An entry is valid iff its mt field != 0.
- Input contract:
  - Valid entries occupy indices 0..cnt-1.
  - cnt = popcount of valid entries, range 0..LINE_SIZE.
  - Entries above cnt are ignored.
- Storage:
  - Buffer of 2*LINE_SIZE entries plus fill counter (0..2*LINE_SIZE-1).
  - Entry 0 is always the oldest entry.
- States: RUN and FLUSH.
- RUN:
  - in_ready = !reset && (fill < LINE_SIZE || out_ready). The out_ready-to-in_ready combinational path is intended.
  - out_valid = (fill >= LINE_SIZE); out_cnt = LINE_SIZE; out_last = 0.
- Input accept (in_valid && in_ready): the cnt entries are written to buffer positions fill..fill+cnt-1, then fill += cnt. A line with cnt = 0 is accepted and changes nothing.
- Output fire (out_valid && out_ready): buffer shifts down by out_cnt, vacated upper entries are zeroed, and fill -= out_cnt.
- Simultaneous accept and fire: apply the shift first, then append at fill-LINE_SIZE. Next fill = fill - LINE_SIZE + cnt. Sustained throughput is one line per cycle.
- Output data:
  - lifm_out and mt_out are buffer entries 0..LINE_SIZE-1, straight from registers (no extra latency).
  - Entries at or above out_cnt read as zero.
- Latency: an accepted entry can appear on the output the cycle after acceptance.
- flush_req in RUN:
  - If an input is accepted in the same cycle, it is appended first.
  - Next state is FLUSH.
  - flush_req in FLUSH is ignored.
- FLUSH:
  - in_ready = 0.
  - out_valid = (fill > 0); out_cnt = min(fill, LINE_SIZE); out_last = (fill <= LINE_SIZE).
  - When fill == 0: flush_done = 1 for that cycle, and next state is RUN.
  - Flush with empty buffer: no output line; flush_done is high the cycle after flush_req.
- Backpressure: out_valid, out_cnt and data stay stable while out_valid && !out_ready.
- Reset: fill = 0, buffer zeroed, state RUN.
  - out_valid = 0, out_last = 0, flush_done = 0, out_cnt = 0 when !out_valid.
  - in_ready is 0 while reset is high.
  - Reset mid-flush discards all buffered data.
- Overflow: impossible by construction, since fill < LINE_SIZE before any append and cnt <= LINE_SIZE.

Decomposition:
- Shared package zvc_pkg holds:
  - LINE_SIZE.
  - ENTRY_WIDTH = WORD_WIDTH + DIST_WIDTH*MAX_LIFM_RSIZ.
  - FILL_WIDTH = $clog2(2*LINE_SIZE).
  - CNT_WIDTH.
  - State encoding (RUN = 0, FLUSH = 1).
- One sub-module: zvc_popcount128, a combinational count of valid entries, mt field != 0.

Test Plan:
- Two lines with cnt = 100 and cnt = 60, out_ready = 1 → one output line with out_cnt = 128 (100 entries from line A, then the first 28 from line B); fill = 32 remains.
- Continuous cnt = 128 lines, out_ready = 1 → one output per cycle; each output equals its input line; in_ready stays 1.
- fill = 32 then flush_req → one line with out_cnt = 32, out_last = 1, entries 32..127 zero; flush_done pulses next cycle; in_ready = 0 during FLUSH.
- fill = 120, accept cnt = 128 (fill 248) with out_ready = 0 → out_valid holds steady and in_ready = 0. Raise out_ready → fill 120, in_ready returns to 1.
- flush_req with fill = 0 → no out_valid; flush_done = 1 the following cycle. Lines with cnt = 0 leave fill unchanged.
- reset asserted during FLUSH with fill = 200 → next cycle fill = 0, out_valid = 0, state RUN; the next input packs from entry 0.

Source files
------------

// File: rtl/zvc_pkg.sv
// Shared constants, entry layout and state encoding for the ZVC line packer.
// No ports; imported by zvc_popcount128 and zvc_line_packer.
package zvc_pkg;

  localparam int unsigned WORD_WIDTH    = 8;
  localparam int unsigned DIST_WIDTH    = 7;
  localparam int unsigned MAX_LIFM_RSIZ = 4;
  localparam int unsigned LINE_SIZE     = 128;

  localparam int unsigned MT_WIDTH    = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int unsigned ENTRY_WIDTH = WORD_WIDTH + MT_WIDTH;
  localparam int unsigned FILL_WIDTH  = $clog2(2 * LINE_SIZE);
  localparam int unsigned CNT_WIDTH   = $clog2(LINE_SIZE) + 1;

  localparam int unsigned LIFM_LINE_W = LINE_SIZE * WORD_WIDTH;
  localparam int unsigned MT_LINE_W   = LINE_SIZE * MT_WIDTH;

  // One buffered entry; an entry is valid iff mt != 0.
  typedef struct packed {
    logic [MT_WIDTH-1:0]   mt;
    logic [WORD_WIDTH-1:0] lifm;
  } entry_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/zvc_popcount128.sv
// Combinational count of valid entries (non-zero mapping-table field) in one line.
// Ports:
//   mt_i  : mapping-table line, LINE_SIZE fields of MT_WIDTH bits
//   cnt_o : number of non-zero fields, 0..LINE_SIZE
module zvc_popcount128
  import zvc_pkg::*;
(
  input  logic [MT_LINE_W-1:0] mt_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < LINE_SIZE; i++) begin
      cnt_o = cnt_o + CNT_WIDTH'(|mt_i[i*MT_WIDTH +: MT_WIDTH]);
    end
  end

endmodule

// File: rtl/zvc_line_packer.sv
// Concatenates the valid entries of successive compressed lines into dense
// LINE_SIZE-entry output lines; a flush drains the partial tail zero-padded.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input line handshake (in_ready depends on out_ready)
//   lifm_comp, mt_comp    : compressed input line, valid entries packed at index 0
//   flush_req             : single-cycle drain request
//   out_valid/out_ready   : output line handshake
//   lifm_out, mt_out      : packed output line, entries >= out_cnt read as zero
//   out_cnt               : valid entries in the output line
//   out_last              : final line of a flush
//   flush_done            : one-cycle pulse when a flush has emptied the buffer
module zvc_line_packer
  import zvc_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LIFM_LINE_W-1:0] lifm_comp,
  input  logic [MT_LINE_W-1:0]   mt_comp,
  input  logic                   flush_req,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LIFM_LINE_W-1:0] lifm_out,
  output logic [MT_LINE_W-1:0]   mt_out,
  output logic [CNT_WIDTH-1:0]   out_cnt,
  output logic                   out_last,
  output logic                   flush_done
);

  localparam int unsigned LINE_BITS   = LINE_SIZE * ENTRY_WIDTH;
  localparam int unsigned BUF_BITS    = 2 * LINE_BITS;
  localparam int unsigned SHIFT_WIDTH = $clog2(BUF_BITS);
  localparam logic [FILL_WIDTH-1:0] FILL_LINE = FILL_WIDTH'(LINE_SIZE);

  state_e                 state_q, state_d;
  logic [FILL_WIDTH-1:0]  fill_q, fill_d;
  logic [FILL_WIDTH-1:0]  base;
  logic [BUF_BITS-1:0]    ent_q, ent_d;
  logic [LINE_BITS-1:0]   in_line;
  logic [CNT_WIDTH-1:0]   in_cnt;
  logic                   accept;
  logic                   fire;

  zvc_popcount128 u_popcount (
    .mt_i  (mt_comp),
    .cnt_o (in_cnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: flush_req is only honoured in RUN; FLUSH ends once empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush_req) state_d = ST_FLUSH;
      ST_FLUSH: if (fill_q == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_cnt    = '0;
    out_last   = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready  = !reset && ((fill_q < FILL_LINE) || out_ready);
        out_valid = (fill_q >= FILL_LINE);
        out_cnt   = out_valid ? CNT_WIDTH'(LINE_SIZE) : '0;
      end
      ST_FLUSH: begin
        out_valid  = (fill_q != '0);
        out_cnt    = (fill_q > FILL_LINE) ? CNT_WIDTH'(LINE_SIZE) : CNT_WIDTH'(fill_q);
        out_last   = out_valid && (fill_q <= FILL_LINE);
        flush_done = (fill_q == '0);
      end
      default: ;
    endcase
  end

  // Buffer update: shift out the fired line, then OR in the new entries.
  // Entries at and above fill are always zero, so OR is an exact append.
  always_comb begin
    accept = in_valid && in_ready;
    fire   = out_valid && out_ready;

    in_line = '0;
    for (int unsigned i = 0; i < LINE_SIZE; i++) begin
      if (CNT_WIDTH'(i) < in_cnt) begin
        in_line[i*ENTRY_WIDTH +: ENTRY_WIDTH] = entry_t'{
          mt:   mt_comp[i*MT_WIDTH +: MT_WIDTH],
          lifm: lifm_comp[i*WORD_WIDTH +: WORD_WIDTH]
        };
      end
    end

    base  = fire ? (fill_q - FILL_WIDTH'(out_cnt)) : fill_q;
    ent_d = fire ? (ent_q >> (SHIFT_WIDTH'(out_cnt) * SHIFT_WIDTH'(ENTRY_WIDTH))) : ent_q;
    if (accept) begin
      ent_d = ent_d | (BUF_BITS'(in_line) << (SHIFT_WIDTH'(base) * SHIFT_WIDTH'(ENTRY_WIDTH)));
    end
    fill_d = base + (accept ? FILL_WIDTH'(in_cnt) : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= '0;
      ent_q  <= '0;
    end else begin
      fill_q <= fill_d;
      ent_q  <= ent_d;
    end
  end

  // Output line is the low half of the buffer, masked to out_cnt
  always_comb begin
    lifm_out = '0;
    mt_out   = '0;
    for (int unsigned i = 0; i < LINE_SIZE; i++) begin
      if (CNT_WIDTH'(i) < out_cnt) begin
        lifm_out[i*WORD_WIDTH +: WORD_WIDTH] = ent_q[i*ENTRY_WIDTH +: WORD_WIDTH];
        mt_out[i*MT_WIDTH +: MT_WIDTH]       = ent_q[i*ENTRY_WIDTH + WORD_WIDTH +: MT_WIDTH];
      end
    end
  end

endmodule
